// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 8;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_e;

  typedef struct packed {
    arb_owner_e            owner;
    logic                  we;
    logic [ARB_ADDR_W-1:0] address;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// rtl/mem_port_arbiter_arb_rr2.sv - two-way round-robin picker, bit 0 = instr, bit 1 = data
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_e last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == OWN_INSTR) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store ports
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_address,
  output logic              instr_gnt,
  output logic              instr_rvalid,
  output logic [DATA_W-1:0] instr_rdata,
  input  logic              data_req,
  input  logic              data_write_enable,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] CNT_LAST = 2'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  arb_owner_e        last_grant_q, last_grant_d;
  arb_cmd_t          cmd_q, cmd_d;
  logic              mem_en_q, mem_en_d;
  logic              instr_rvalid_q, instr_rvalid_d;
  logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
  logic              data_rvalid_q, data_rvalid_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic [1:0]        pick;
  logic [1:0]        grant;

  arb_rr2 u_rr (
    .req        ({data_req, instr_req}),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  // Grants are only offered from IDLE and never while reset is being applied.
  assign grant     = (state_q == ARB_IDLE && !rst) ? pick : 2'b00;
  assign instr_gnt = grant[0];
  assign data_gnt  = grant[1];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    cmd_d          = cmd_q;
    mem_en_d       = 1'b0;
    instr_rvalid_d = 1'b0;
    instr_rdata_d  = instr_rdata_q;
    data_rvalid_d  = 1'b0;
    data_rdata_d   = data_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant[1]) begin
          cmd_d.owner   = OWN_DATA;
          cmd_d.we      = data_write_enable;
          cmd_d.address = data_address;
          cmd_d.wdata   = data_write_enable ? data_wdata : '0;
        end else if (grant[0]) begin
          cmd_d.owner   = OWN_INSTR;
          cmd_d.we      = 1'b0;
          cmd_d.address = instr_address;
          cmd_d.wdata   = '0;
        end
        if (|grant) begin
          last_grant_d = cmd_d.owner;
          mem_en_d     = 1'b1;
          state_d      = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = 2'd0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 2'd0;
          state_d = ARB_RESP;
          if (cmd_q.owner == OWN_DATA) begin
            data_rvalid_d = 1'b1;
            data_rdata_d  = cmd_q.we ? '0 : mem_rdata;
          end else begin
            instr_rvalid_d = 1'b1;
            instr_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      cnt_q          <= 2'd0;
      last_grant_q   <= OWN_INSTR;
      cmd_q          <= '0;
      mem_en_q       <= 1'b0;
      instr_rvalid_q <= 1'b0;
      instr_rdata_q  <= '0;
      data_rvalid_q  <= 1'b0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      cmd_q          <= cmd_d;
      mem_en_q       <= mem_en_d;
      instr_rvalid_q <= instr_rvalid_d;
      instr_rdata_q  <= instr_rdata_d;
      data_rvalid_q  <= data_rvalid_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  // Write strobe and data are forced low outside the single mem_en cycle.
  assign mem_en           = mem_en_q;
  assign mem_write_enable = mem_en_q & cmd_q.we;
  assign mem_address      = cmd_q.address;
  assign mem_wdata        = mem_en_q ? cmd_q.wdata : '0;
  assign instr_rvalid     = instr_rvalid_q;
  assign instr_rdata      = instr_rdata_q;
  assign data_rvalid      = data_rvalid_q;
  assign data_rdata       = data_rdata_q;

endmodule
